// File: rtl/mult_div_sequencer_if.sv
// E/D-stage bundle between the pipeline and the multiply/divide sequencer.
// The pipeline side uses master; the sequencer uses slave.
interface mult_div_sequencer_if;
  logic        req;
  logic        e_ismultdiv;
  logic [2:0]  e_multsel;
  logic [31:0] e_v1;
  logic [31:0] e_v2;
  logic        d_ismultdiv;
  logic        busy;
  logic        stall_md;
  logic [31:0] md_rd;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req, e_ismultdiv, e_multsel, e_v1, e_v2, d_ismultdiv,
    input  busy, stall_md, md_rd, hi, lo
  );

  modport slave (
    input  req, e_ismultdiv, e_multsel, e_v1, e_v2, d_ismultdiv,
    output busy, stall_md, md_rd, hi, lo
  );
endinterface

// File: rtl/mult_div_sequencer.sv
// MIPS E-stage multiply/divide sequencer: owns HI/LO and models the MULT/DIV latency.
// The result is computed at start, held as pending, and committed after N busy cycles.
module mult_div_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic              clk,
  input logic              reset_n,
  mult_div_sequencer_if.slave md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [31:0]   hi_q, lo_q, pend_hi, pend_lo;
  logic          busy_q;

  logic          start, mt_ok;
  logic [31:0]   a, b;
  logic [63:0]   prod_s, prod_u;
  logic          sdiv, neg_a, neg_b, div_zero;
  logic [31:0]   ua, ub, uq, ur, q_f, r_f;
  logic [31:0]   res_hi, res_lo;

  assign a     = md.e_v1;
  assign b     = md.e_v2;
  assign start = md.e_ismultdiv & ~md.e_multsel[2] & (state == IDLE) & ~md.req;
  assign mt_ok = md.e_ismultdiv & (md.e_multsel[2:1] == 2'b11) & (state == IDLE) & ~md.req;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide is done on magnitudes so 0x8000_0000 / -1 needs no special case.
  assign sdiv     = (md.e_multsel[1:0] == 2'd2);
  assign neg_a    = sdiv & a[31];
  assign neg_b    = sdiv & b[31];
  assign div_zero = (b == 32'd0);
  assign ua       = neg_a ? (~a + 32'd1) : a;
  assign ub       = div_zero ? 32'd1 : (neg_b ? (~b + 32'd1) : b);
  assign uq       = ua / ub;
  assign ur       = ua % ub;
  assign q_f      = (neg_a ^ neg_b) ? (~uq + 32'd1) : uq;
  assign r_f      = neg_a ? (~ur + 32'd1) : ur;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md.e_multsel[1:0])
      2'd0:    {res_hi, res_lo} = prod_s;
      2'd1:    {res_hi, res_lo} = prod_u;
      default: begin
        res_hi = div_zero ? a : r_f;
        res_lo = div_zero ? 32'hFFFF_FFFF : q_f;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            busy_q  <= 1'b1;
            if (md.e_multsel[1]) begin
              state <= DIV;
              count <= CW'(DIV_CYCLES);
            end else begin
              state <= MUL;
              count <= CW'(MULT_CYCLES);
            end
          end else if (mt_ok) begin
            if (md.e_multsel[0]) lo_q <= a;
            else                 hi_q <= a;
          end
        end
        default: begin
          if (count == CW'(1)) begin
            hi_q   <= pend_hi;
            lo_q   <= pend_lo;
            state  <= IDLE;
            busy_q <= 1'b0;
            count  <= '0;
          end else begin
            count <= count - CW'(1);
          end
        end
      endcase
    end
  end

  assign md.busy     = busy_q;
  assign md.stall_md = md.d_ismultdiv & (busy_q | start);
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_rd    = (md.e_multsel == 3'd4) ? hi_q :
                       (md.e_multsel == 3'd5) ? lo_q : 32'd0;
endmodule
